// File: rtl/cache_req_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_req_ctrl_if
//   Bundles the processor request/response handshake and the cache-side bus of
//   cache_req_ctrl.
//   slave  : view of cache_req_ctrl (consumes requests, drives the cache)
//   master : view of the environment (processor + cache)
//   req_*   : request offer (valid/ready, rw, addr, wdata)
//   rsp_*   : one-cycle completion pulse, read data, hit flag
//   cache_* : enab/rw/addr/wdata to the cache, rdata/hit from the cache
// -----------------------------------------------------------------------------
interface cache_req_ctrl_if #(
   parameter int a_width = 8,
   parameter int d_width = 8
);
   logic               req_valid;
   logic               req_ready;
   logic               req_rw;
   logic [a_width-1:0] req_addr;
   logic [d_width-1:0] req_wdata;
   logic               rsp_valid;
   logic [d_width-1:0] rsp_rdata;
   logic               rsp_hit;
   logic               cache_enab;
   logic               cache_rw;
   logic [a_width-1:0] cache_addr;
   logic [d_width-1:0] cache_wdata;
   logic [d_width-1:0] cache_rdata;
   logic               cache_hit;

   modport slave (
      input  req_valid, req_rw, req_addr, req_wdata, cache_rdata, cache_hit,
      output req_ready, rsp_valid, rsp_rdata, rsp_hit,
             cache_enab, cache_rw, cache_addr, cache_wdata
   );

   modport master (
      output req_valid, req_rw, req_addr, req_wdata, cache_rdata, cache_hit,
      input  req_ready, rsp_valid, rsp_rdata, rsp_hit,
             cache_enab, cache_rw, cache_addr, cache_wdata
   );
endinterface

// File: rtl/cache_req_ctrl.sv
// -----------------------------------------------------------------------------
// cache_req_ctrl
//   Front end for the 4-entry LRU cache. Buffers load/store requests in a
//   DEPTH-entry FIFO, issues one at a time with stable cache_* signals, and
//   times the cache's fixed hit/miss latencies (the cache has no done strobe).
//   Completion is reported by a one-cycle rsp_valid pulse with rsp_hit and,
//   for reads, rsp_rdata (held until the next read completes).
//
//   Ports:
//     clk      : clock, all state updates on posedge
//     clr      : synchronous active-high reset (flushes FIFO, drops in-flight)
//     bus      : cache_req_ctrl_if.slave (request, response and cache buses)
//     hit_cnt  : (CACHE_REQ_STATS_EN only) saturating count of hits
//     miss_cnt : (CACHE_REQ_STATS_EN only) saturating count of misses
//
//   Optional feature macro: CACHE_REQ_STATS_EN
// -----------------------------------------------------------------------------
module cache_req_ctrl #(
   parameter int a_width  = 8,
   parameter int d_width  = 8,
   parameter int DEPTH    = 4,
   parameter int HIT_LAT  = 2,
   parameter int MISS_LAT = 12
) (
   input  logic                clk,
   input  logic                clr,
   cache_req_ctrl_if.slave     bus
`ifdef CACHE_REQ_STATS_EN
   ,
   output logic [15:0]         hit_cnt,
   output logic [15:0]         miss_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(MISS_LAT + 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] HIT_C    = CW'(HIT_LAT);
   localparam logic [CW-1:0] MISS_C   = CW'(MISS_LAT);

   typedef struct packed {
      logic               rw;
      logic [a_width-1:0] addr;
      logic [d_width-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {IDLE, PROBE, MISS, DONE} state_t;

   // ---------------- request FIFO ----------------
   req_t          fifo_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          full, empty, push, pop;

   state_t        state_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit_done, miss_done;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign push  = bus.req_valid && !full;
   // Only pop from IDLE, so a single request is ever outstanding.
   assign pop   = (state_q == IDLE) && !empty;

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= '{rw: bus.req_rw, addr: bus.req_addr, wdata: bus.req_wdata};
            wr_ptr_q         <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------- issue / latency FSM ----------------
   logic               cache_enab_q, cache_rw_q;
   logic [a_width-1:0] cache_addr_q;
   logic [d_width-1:0] cache_wdata_q;
   logic               rsp_valid_q, rsp_hit_q;
   logic [d_width-1:0] rsp_rdata_q;

   // cnt_d is the value cnt takes at the coming edge; decisions are made on
   // the edge where it reaches the latency, which gives DONE at pop+LAT.
   assign cnt_d     = cnt_q + CW'(1);
   assign hit_done  = (state_q == PROBE) && (cnt_d == HIT_C) && bus.cache_hit;
   assign miss_done = (state_q == MISS)  && (cnt_d == MISS_C);

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         cache_enab_q  <= 1'b0;
         cache_rw_q    <= 1'b0;
         cache_addr_q  <= '0;
         cache_wdata_q <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_hit_q     <= 1'b0;
         rsp_rdata_q   <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  cache_rw_q    <= fifo_q[rd_ptr_q].rw;
                  cache_addr_q  <= fifo_q[rd_ptr_q].addr;
                  cache_wdata_q <= fifo_q[rd_ptr_q].wdata;
                  cache_enab_q  <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= PROBE;
               end
            end
            PROBE: begin
               cnt_q <= cnt_d;
               if (cnt_d == HIT_C) begin
                  if (hit_done) begin
                     if (!cache_rw_q) rsp_rdata_q <= bus.cache_rdata;
                     rsp_hit_q    <= 1'b1;
                     rsp_valid_q  <= 1'b1;
                     cache_enab_q <= 1'b0;
                     state_q      <= DONE;
                  end else begin
                     state_q <= MISS;
                  end
               end
            end
            MISS: begin
               cnt_q <= cnt_d;
               if (miss_done) begin
                  if (!cache_rw_q) rsp_rdata_q <= bus.cache_rdata;
                  rsp_hit_q    <= 1'b0;
                  rsp_valid_q  <= 1'b1;
                  cache_enab_q <= 1'b0;
                  state_q      <= DONE;
               end
            end
            // enab is low for this cycle, returning the cache to its idle state
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready   = !full;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_hit     = rsp_hit_q;
   assign bus.cache_enab  = cache_enab_q;
   assign bus.cache_rw    = cache_rw_q;
   assign bus.cache_addr  = cache_addr_q;
   assign bus.cache_wdata = cache_wdata_q;

`ifdef CACHE_REQ_STATS_EN
   logic [15:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit_done  && hit_cnt_q  != 16'hFFFF) hit_cnt_q  <= hit_cnt_q  + 16'd1;
         if (miss_done && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_req_ctrl
//   Directed bench for cache_req_ctrl. A small behavioural cache (address ->
//   "present" flag plus backing memory) answers the cache bus; all expected
//   latencies, hit flags and read data are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_cache_req_ctrl;
   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   cache_req_ctrl_if #(.a_width(8), .d_width(8)) bus ();

`ifdef CACHE_REQ_STATS_EN
   logic [15:0] hit_cnt, miss_cnt;
`endif

   cache_req_ctrl #(
      .a_width(8), .d_width(8), .DEPTH(4), .HIT_LAT(2), .MISS_LAT(12)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus)
`ifdef CACHE_REQ_STATS_EN
      ,
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural cache ----------------
   logic [7:0] mem    [256];
   logic       cached [256];
   logic       seen = 1'b0;

   always @(negedge clk) begin
      if (bus.cache_enab && !seen) begin
         seen          = 1'b1;
         bus.cache_hit = cached[bus.cache_addr];
         if (bus.cache_rw) begin
            mem[bus.cache_addr] = bus.cache_wdata;
            bus.cache_rdata     = bus.cache_wdata;
         end else begin
            bus.cache_rdata = mem[bus.cache_addr];
         end
         cached[bus.cache_addr] = 1'b1;
      end else if (!bus.cache_enab) begin
         seen          = 1'b0;
         bus.cache_hit = 1'b0;
      end
   end

   // ---------------- response monitor ----------------
   logic       rq_hit  [$];
   logic [7:0] rq_data [$];

   always @(negedge clk) begin
      if (bus.rsp_valid) begin
         rq_hit.push_back(bus.rsp_hit);
         rq_data.push_back(bus.rsp_rdata);
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       exp_hit;
      logic [7:0] exp_rdata;
      int         exp_lat;   // posedges from push edge to rsp_valid
   } vec_t;

   vec_t vt [7];

   // Called at a negedge; returns at the negedge following the push edge.
   task automatic push_req(input logic rw, input logic [7:0] a, input logic [7:0] d);
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      push_req(v.rw, v.addr, v.wdata);
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
      chk($sformatf("v%0d rsp_hit", idx), bus.rsp_hit, v.exp_hit);
      chk($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata, v.exp_rdata);
      chk($sformatf("v%0d enab_in_done", idx), bus.cache_enab, 0);
      chk($sformatf("v%0d cache_addr", idx), bus.cache_addr, v.addr);
      chk($sformatf("v%0d cache_rw", idx), bus.cache_rw, v.rw);
      @(negedge clk);
      chk($sformatf("v%0d pulse_1cyc", idx), bus.rsp_valid, 0);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] b_addr [5];
      logic [7:0] b_data [5];
      logic       b_hit  [5];
      int         w;

      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'h00;
         cached[i] = 1'b0;
      end
      mem[8'h05] = 8'h3C;
      mem[8'h10] = 8'h55;
      mem[8'h20] = 8'hC3;
      mem[8'h21] = 8'h99;
      bus.cache_hit   = 1'b0;
      bus.cache_rdata = 8'h00;
      bus.req_valid   = 1'b0;
      bus.req_rw      = 1'b0;
      bus.req_addr    = 8'h00;
      bus.req_wdata   = 8'h00;

      //            rw    addr   wdata  hit   rdata  lat
      vt[0] = '{1'b0, 8'h05, 8'h00, 1'b0, 8'h3C, 13};  // read miss
      vt[1] = '{1'b0, 8'h05, 8'h00, 1'b1, 8'h3C, 3};   // read hit
      vt[2] = '{1'b1, 8'h02, 8'hA7, 1'b0, 8'h3C, 13};  // write miss, rdata held
      vt[3] = '{1'b0, 8'h02, 8'h00, 1'b1, 8'hA7, 3};   // read back hit
      vt[4] = '{1'b0, 8'h10, 8'h00, 1'b0, 8'h55, 13};  // read miss
      vt[5] = '{1'b1, 8'h05, 8'h5A, 1'b1, 8'h55, 3};   // write hit, rdata held
      vt[6] = '{1'b0, 8'h05, 8'h00, 1'b1, 8'h5A, 3};   // read hit new data

      // ---- reset ----
      clr = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst req_ready",   bus.req_ready,   1);
      chk("rst rsp_valid",   bus.rsp_valid,   0);
      chk("rst rsp_rdata",   bus.rsp_rdata,   0);
      chk("rst rsp_hit",     bus.rsp_hit,     0);
      chk("rst cache_enab",  bus.cache_enab,  0);
      chk("rst cache_rw",    bus.cache_rw,    0);
      chk("rst cache_addr",  bus.cache_addr,  0);
      chk("rst cache_wdata", bus.cache_wdata, 0);
      clr = 1'b0;
      @(negedge clk);

      // ---- single-request vectors ----
      for (int i = 0; i < 7; i++) run_vec(i, vt[i]);
`ifdef CACHE_REQ_STATS_EN
      chk("stats miss_cnt", miss_cnt, 3);
      chk("stats hit_cnt",  hit_cnt,  4);
`endif

      // ---- FIFO burst: five back-to-back pushes ----
      rq_hit.delete();
      rq_data.delete();
      b_addr = '{8'h05, 8'h20, 8'h02, 8'h21, 8'h10};
      b_data = '{8'h5A, 8'hC3, 8'hA7, 8'h99, 8'h55};
      b_hit  = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("burst ready%0d", i), bus.req_ready, 1);
         bus.req_valid = 1'b1;
         bus.req_rw    = 1'b0;
         bus.req_addr  = b_addr[i];
         bus.req_wdata = 8'h00;
         @(posedge clk);
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      chk("burst full", bus.req_ready, 0);
      w = 0;
      while (rq_hit.size() < 5 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("burst count", rq_hit.size(), 5);
      for (int i = 0; i < 5 && i < rq_hit.size(); i++) begin
         chk($sformatf("burst hit%0d", i),   rq_hit[i],  b_hit[i]);
         chk($sformatf("burst rdata%0d", i), rq_data[i], b_data[i]);
      end
      chk("burst drained", bus.req_ready, 1);
      repeat (3) @(negedge clk);

      // ---- clr during a miss, with a second request queued ----
      rq_hit.delete();
      rq_data.delete();
      push_req(1'b0, 8'h30, 8'h00);
      push_req(1'b0, 8'h31, 8'h00);
      repeat (5) @(negedge clk);
      chk("clr pre enab", bus.cache_enab, 1);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      chk("clr enab",      bus.cache_enab, 0);
      chk("clr rsp_valid", bus.rsp_valid,  0);
      chk("clr ready",     bus.req_ready,  1);
`ifdef CACHE_REQ_STATS_EN
      chk("clr miss_cnt", miss_cnt, 0);
      chk("clr hit_cnt",  hit_cnt,  0);
`endif
      repeat (30) @(negedge clk);
      chk("clr no rsp", rq_hit.size(), 0);
      chk("clr idle enab", bus.cache_enab, 0);
      run_vec(7, '{1'b0, 8'h05, 8'h00, 1'b1, 8'h5A, 3});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
